// File: rtl/qu_common.sv
// Shared reservation-station types: entry geometry, the stored uop cell and the CDB bundle.
package qu_common;

  localparam int RES_ST_DEPTH    = 8;
  localparam int RES_ST_ADDR_W   = $clog2(RES_ST_DEPTH);
  localparam int RES_ST_CNT_W    = RES_ST_ADDR_W + 1;
  localparam int RES_ST_OP_WIDTH = 6;
  localparam int ROB_DEPTH       = 16;
  localparam int ROB_ADDR_W      = $clog2(ROB_DEPTH);

  typedef logic [RES_ST_ADDR_W-1:0] res_st_addr_t;
  typedef logic [ROB_ADDR_W-1:0]    rob_addr_t;

  // rj/rk are the operand-ready bits; rename drives them as the inverse of its busy table.
  typedef struct packed {
    logic [RES_ST_OP_WIDTH-1:0] op;
    res_st_addr_t               qj;
    res_st_addr_t               qk;
    logic [31:0]                vj;
    logic [31:0]                vk;
    logic [31:0]                a;
    rob_addr_t                  rob_addr;
    logic                       rj;
    logic                       rk;
  } res_st_cell_t;

  typedef struct packed {
    logic         valid;
    res_st_addr_t tag;
    logic [31:0]  data;
  } cdb_t;

  // A pending operand captures the broadcast when its producer tag matches.
  function automatic logic cdb_hit(input cdb_t cdb, input logic rdy, input res_st_addr_t q);
    return cdb.valid && !rdy && (q == cdb.tag);
  endfunction

endpackage

// File: rtl/reservation_station_rs_issue_select.sv
// Lowest-index priority encoder: ready vector in, (valid, index) out. Purely combinational.
module rs_issue_select #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     ready_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (ready_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: holds renamed uops, snoops the CDB for operands, issues one ready entry per cycle.
// Issue fields are combinational from the entry array; a stalled selection is pinned until accepted or flushed.
module reservation_station
  import qu_common::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_in,
  input  logic                       res_st_wr_en_in,
  input  res_st_addr_t               res_st_wr_addr_in,
  input  res_st_cell_t               res_st_data_in,
  output logic                       res_st_full_out,
  output logic                       res_st_overflow_out,
  output logic [RES_ST_CNT_W-1:0]    res_st_count_out,
  input  logic                       cdb_valid_in,
  input  res_st_addr_t               cdb_tag_in,
  input  logic [31:0]                cdb_data_in,
  output logic                       issue_valid_out,
  input  logic                       issue_ready_in,
  output logic [RES_ST_OP_WIDTH-1:0] issue_op_out,
  output logic [31:0]                issue_vj_out,
  output logic [31:0]                issue_vk_out,
  output logic [31:0]                issue_a_out,
  output rob_addr_t                  issue_rob_addr_out,
  output res_st_addr_t               issue_tag_out
);

  res_st_cell_t             cells_q [RES_ST_DEPTH];
  res_st_cell_t             cells_d [RES_ST_DEPTH];
  logic [RES_ST_DEPTH-1:0]  busy_q, busy_d;
  logic                     hold_vld_q, hold_vld_d;
  res_st_addr_t             hold_idx_q, hold_idx_d;
  logic                     overflow_q, overflow_d;
  logic [RES_ST_CNT_W-1:0]  count_q, count_d;

  cdb_t                     cdb;
  logic [RES_ST_DEPTH-1:0]  ready_vec;
  logic                     enc_vld;
  res_st_addr_t             enc_idx;
  logic                     sel_vld;
  res_st_addr_t             sel_idx;
  logic                     fire;
  logic                     wr_ok;
  res_st_cell_t             wr_cell;

  assign cdb = '{valid: cdb_valid_in, tag: cdb_tag_in, data: cdb_data_in};

  always_comb begin
    for (int i = 0; i < RES_ST_DEPTH; i++) begin
      ready_vec[i] = busy_q[i] && cells_q[i].rj && cells_q[i].rk;
    end
  end

  rs_issue_select #(.N(RES_ST_DEPTH), .IDX_W(RES_ST_ADDR_W)) u_select (
    .ready_i (ready_vec),
    .valid_o (enc_vld),
    .idx_o   (enc_idx)
  );

  // A held index stays ready: its entry is busy and ready bits never drop while busy.
  assign sel_vld         = hold_vld_q || enc_vld;
  assign sel_idx         = hold_vld_q ? hold_idx_q : enc_idx;
  assign issue_valid_out = sel_vld && !flush_in;
  assign fire            = issue_valid_out && issue_ready_in;
  assign wr_ok           = res_st_wr_en_in && !busy_q[res_st_wr_addr_in];

  assign issue_op_out       = issue_valid_out ? cells_q[sel_idx].op       : '0;
  assign issue_vj_out       = issue_valid_out ? cells_q[sel_idx].vj       : '0;
  assign issue_vk_out       = issue_valid_out ? cells_q[sel_idx].vk       : '0;
  assign issue_a_out        = issue_valid_out ? cells_q[sel_idx].a        : '0;
  assign issue_rob_addr_out = issue_valid_out ? cells_q[sel_idx].rob_addr : '0;
  assign issue_tag_out      = issue_valid_out ? sel_idx                   : '0;

  // Incoming operands that match a same-cycle broadcast are stored already ready.
  always_comb begin
    wr_cell = res_st_data_in;
    if (cdb_hit(cdb, res_st_data_in.rj, res_st_data_in.qj)) begin
      wr_cell.vj = cdb.data;
      wr_cell.rj = 1'b1;
    end
    if (cdb_hit(cdb, res_st_data_in.rk, res_st_data_in.qk)) begin
      wr_cell.vk = cdb.data;
      wr_cell.rk = 1'b1;
    end
  end

  always_comb begin
    cells_d = cells_q;
    busy_d  = busy_q;
    for (int i = 0; i < RES_ST_DEPTH; i++) begin
      if (busy_q[i] && cdb_hit(cdb, cells_q[i].rj, cells_q[i].qj)) begin
        cells_d[i].vj = cdb.data;
        cells_d[i].rj = 1'b1;
      end
      if (busy_q[i] && cdb_hit(cdb, cells_q[i].rk, cells_q[i].qk)) begin
        cells_d[i].vk = cdb.data;
        cells_d[i].rk = 1'b1;
      end
    end
    if (fire) begin
      busy_d[sel_idx] = 1'b0;
    end
    if (wr_ok) begin
      cells_d[res_st_wr_addr_in] = wr_cell;
      busy_d[res_st_wr_addr_in]  = 1'b1;
    end
    if (flush_in) begin
      busy_d = '0;
    end

    overflow_d = res_st_wr_en_in && busy_q[res_st_wr_addr_in] && !flush_in;
    hold_vld_d = issue_valid_out && !issue_ready_in;
    hold_idx_d = sel_idx;

    count_d = '0;
    for (int i = 0; i < RES_ST_DEPTH; i++) begin
      count_d = count_d + RES_ST_CNT_W'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RES_ST_DEPTH; i++) begin
        cells_q[i] <= '0;
      end
      busy_q     <= '0;
      hold_vld_q <= 1'b0;
      hold_idx_q <= '0;
      overflow_q <= 1'b0;
      count_q    <= '0;
    end else begin
      for (int i = 0; i < RES_ST_DEPTH; i++) begin
        cells_q[i] <= cells_d[i];
      end
      busy_q     <= busy_d;
      hold_vld_q <= hold_vld_d;
      hold_idx_q <= hold_idx_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
    end
  end

  assign res_st_overflow_out = overflow_q;
  assign res_st_count_out    = count_q;
  assign res_st_full_out     = (count_q == RES_ST_CNT_W'(RES_ST_DEPTH));

endmodule

// File: tb/tb_reservation_station.sv
// Randomised and directed bench for reservation_station against a queue-level reference model.
module tb_reservation_station;
  import qu_common::*;

  logic                       clk;
  logic                       rst;
  logic                       flush;
  logic                       wr_en;
  res_st_addr_t               wr_addr;
  res_st_cell_t               wr_dat;
  logic                       full;
  logic                       ovf;
  logic [RES_ST_CNT_W-1:0]    count;
  logic                       cdb_v;
  res_st_addr_t               cdb_tag;
  logic [31:0]                cdb_dat;
  logic                       iss_vld;
  logic                       rdy;
  logic [RES_ST_OP_WIDTH-1:0] iss_op;
  logic [31:0]                iss_vj, iss_vk, iss_a;
  rob_addr_t                  iss_rob;
  res_st_addr_t               iss_tag;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: which slots hold a uop, their contents, and the index pinned by a stall.
  bit           m_busy [RES_ST_DEPTH];
  res_st_cell_t m_cell [RES_ST_DEPTH];
  int           m_stall;
  bit           m_ovf;

  reservation_station dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush_in            (flush),
    .res_st_wr_en_in     (wr_en),
    .res_st_wr_addr_in   (wr_addr),
    .res_st_data_in      (wr_dat),
    .res_st_full_out     (full),
    .res_st_overflow_out (ovf),
    .res_st_count_out    (count),
    .cdb_valid_in        (cdb_v),
    .cdb_tag_in          (cdb_tag),
    .cdb_data_in         (cdb_dat),
    .issue_valid_out     (iss_vld),
    .issue_ready_in      (rdy),
    .issue_op_out        (iss_op),
    .issue_vj_out        (iss_vj),
    .issue_vk_out        (iss_vk),
    .issue_a_out         (iss_a),
    .issue_rob_addr_out  (iss_rob),
    .issue_tag_out       (iss_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic res_st_cell_t mk(input int op, input int qj, input bit rj, input logic [31:0] vj,
                                      input int qk, input bit rk, input logic [31:0] vk,
                                      input logic [31:0] a);
    res_st_cell_t c;
    c.op       = RES_ST_OP_WIDTH'(op);
    c.qj       = res_st_addr_t'(qj);
    c.rj       = rj;
    c.vj       = vj;
    c.qk       = res_st_addr_t'(qk);
    c.rk       = rk;
    c.vk       = vk;
    c.a        = a;
    c.rob_addr = rob_addr_t'(a + 32'd3);
    return c;
  endfunction

  task automatic idle();
    flush   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_dat  = '0;
    cdb_v   = 1'b0;
    cdb_tag = '0;
    cdb_dat = '0;
    rdy     = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < RES_ST_DEPTH; i++) begin
      m_busy[i] = 1'b0;
      m_cell[i] = '0;
    end
    m_stall = -1;
    m_ovf   = 1'b0;
  endtask

  function automatic int model_pick();
    if (m_stall >= 0) return m_stall;
    for (int i = 0; i < RES_ST_DEPTH; i++)
      if (m_busy[i] && m_cell[i].rj && m_cell[i].rk) return i;
    return -1;
  endfunction

  task automatic compare_outputs();
    int           idx;
    bit           v;
    int           cnt;
    res_st_cell_t e;
    idx = model_pick();
    v   = (idx >= 0) && !flush;
    e   = '0;
    if (v) e = m_cell[idx];
    cnt = 0;
    for (int i = 0; i < RES_ST_DEPTH; i++) cnt += int'(m_busy[i]);
    check("issue_valid", iss_vld, v);
    check("issue_tag", iss_tag, v ? idx : 0);
    check("issue_op", iss_op, e.op);
    check("issue_vj", iss_vj, e.vj);
    check("issue_vk", iss_vk, e.vk);
    check("issue_a", iss_a, e.a);
    check("issue_rob", iss_rob, e.rob_addr);
    check("count", count, cnt);
    check("full", full, cnt == RES_ST_DEPTH);
    check("overflow", ovf, m_ovf);
  endtask

  task automatic model_edge();
    int           idx;
    bit           v;
    bit           pre_busy [RES_ST_DEPTH];
    res_st_cell_t c;
    idx = model_pick();
    v   = (idx >= 0) && !flush;
    for (int i = 0; i < RES_ST_DEPTH; i++) pre_busy[i] = m_busy[i];
    m_ovf = wr_en && pre_busy[wr_addr] && !flush;
    for (int i = 0; i < RES_ST_DEPTH; i++) begin
      if (pre_busy[i] && cdb_v && !m_cell[i].rj && m_cell[i].qj == cdb_tag) begin
        m_cell[i].vj = cdb_dat;
        m_cell[i].rj = 1'b1;
      end
      if (pre_busy[i] && cdb_v && !m_cell[i].rk && m_cell[i].qk == cdb_tag) begin
        m_cell[i].vk = cdb_dat;
        m_cell[i].rk = 1'b1;
      end
    end
    if (v && rdy) m_busy[idx] = 1'b0;
    if (wr_en && !pre_busy[wr_addr]) begin
      c = wr_dat;
      if (cdb_v && !c.rj && c.qj == cdb_tag) begin c.vj = cdb_dat; c.rj = 1'b1; end
      if (cdb_v && !c.rk && c.qk == cdb_tag) begin c.vk = cdb_dat; c.rk = 1'b1; end
      m_cell[wr_addr] = c;
      m_busy[wr_addr] = 1'b1;
    end
    if (flush) begin
      for (int i = 0; i < RES_ST_DEPTH; i++) m_busy[i] = 1'b0;
      m_stall = -1;
    end else begin
      m_stall = (v && !rdy) ? idx : -1;
    end
  endtask

  // Inputs are applied just after a rising edge; outputs are compared at the falling edge.
  task automatic step();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic write(input int addr, input res_st_cell_t c);
    wr_en   = 1'b1;
    wr_addr = res_st_addr_t'(addr);
    wr_dat  = c;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_valid", iss_vld, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_ovf", ovf, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Simple write then issue.
    write(2, mk(1, 0, 1, 5, 0, 1, 7, 32'h10));
    step();
    idle();
    check("t1_valid", iss_vld, 1);
    check("t1_tag", iss_tag, 2);
    check("t1_vj", iss_vj, 5);
    check("t1_vk", iss_vk, 7);
    step();
    check("t1_count", count, 0);

    // CDB wakeup; an entry on a different tag stays pending.
    write(0, mk(2, 3, 0, 0, 0, 1, 1, 32'h20));
    step();
    write(5, mk(3, 4, 0, 0, 0, 1, 2, 32'h30));
    step();
    idle();
    cdb_v = 1'b1; cdb_tag = 3'd3; cdb_dat = 32'hDEAD;
    step();
    idle();
    check("t2_tag", iss_tag, 0);
    check("t2_vj", iss_vj, 32'hDEAD);
    step();
    check("t2_valid", iss_vld, 0);
    check("t2_count", count, 1);
    flush = 1'b1;
    step();
    idle();

    // Write/CDB bypass.
    write(1, mk(4, 0, 1, 9, 6, 0, 0, 32'h40));
    cdb_v = 1'b1; cdb_tag = 3'd6; cdb_dat = 32'h42;
    step();
    idle();
    check("t3_tag", iss_tag, 1);
    check("t3_vk", iss_vk, 32'h42);
    step();

    // Fill, overflow, payload preserved.
    for (int i = 0; i < RES_ST_DEPTH; i++) begin
      write(i, mk(i, 7, 0, i, 7, 0, 0, 100 + i));
      rdy = 1'b0;
      step();
    end
    idle();
    rdy = 1'b0;
    check("t4_full", full, 1);
    check("t4_count", count, 8);
    write(0, mk(9, 1, 1, 1, 1, 1, 1, 999));
    step();
    idle();
    rdy = 1'b0;
    check("t4_ovf", ovf, 1);
    cdb_v = 1'b1; cdb_tag = 3'd7; cdb_dat = 32'h77;
    step();
    idle();
    check("t4_ovf_pulse", ovf, 0);
    check("t4_a", iss_a, 100);
    check("t4_vj", iss_vj, 32'h77);
    flush = 1'b1;
    step();
    idle();

    // Stall ordering: index 1 held, then 4.
    write(4, mk(5, 5, 0, 0, 0, 1, 4, 32'h50));
    step();
    write(1, mk(6, 5, 0, 0, 0, 1, 1, 32'h60));
    step();
    idle();
    rdy = 1'b0;
    cdb_v = 1'b1; cdb_tag = 3'd5; cdb_dat = 32'h55;
    step();
    idle();
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("t5_hold_tag", iss_tag, 1);
      check("t5_hold_a", iss_a, 32'h60);
      step();
    end
    rdy = 1'b1;
    check("t5_first", iss_tag, 1);
    step();
    check("t5_second", iss_tag, 4);
    step();

    // Flush during a stall.
    write(2, mk(7, 0, 1, 1, 0, 1, 1, 32'h70));
    rdy = 1'b0;
    step();
    write(3, mk(8, 0, 1, 2, 0, 1, 2, 32'h80));
    rdy = 1'b0;
    step();
    idle();
    flush = 1'b1;
    rdy = 1'b0;
    step();
    idle();
    check("t6_count", count, 0);
    check("t6_valid", iss_vld, 0);

    // Asynchronous reset mid-stall with an overflow pulse pending.
    write(0, mk(1, 0, 1, 3, 0, 1, 3, 32'h90));
    rdy = 1'b0;
    step();
    write(0, mk(1, 0, 1, 4, 0, 1, 4, 32'h91));
    rdy = 1'b0;
    step();
    #2 rst = 1'b0;
    #1;
    check("t7_valid", iss_vld, 0);
    check("t7_count", count, 0);
    check("t7_ovf", ovf, 0);
    check("t7_vj", iss_vj, 0);
    model_reset();
    idle();
    @(posedge clk);
    #1 rst = 1'b1;

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      idle();
      wr_en   = ($urandom_range(0, 99) < 55);
      wr_addr = res_st_addr_t'($urandom_range(0, RES_ST_DEPTH - 1));
      wr_dat  = mk($urandom_range(0, 63), $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom,
                   $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom, $urandom);
      cdb_v   = ($urandom_range(0, 99) < 40);
      cdb_tag = res_st_addr_t'($urandom_range(0, RES_ST_DEPTH - 1));
      cdb_dat = $urandom;
      rdy     = ($urandom_range(0, 99) < 60);
      flush   = ($urandom_range(0, 99) < 3);
      step();
    end
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
